i2c_read_rdata: RTL

Bit-banged I2C register-read master: the read-side counterpart to the team's I2C write master, driving the same open-drain SDA/SCL pins of the HDMI transmitter configuration bus. On a GO handshake it issues START, slave address (write), register address, repeated START, slave address (read), clocks in one or two data bytes, then STOP. It returns the data on RDATA and flags any missing slave acknowledge. Each PT_CK tick is one quarter of an SCL bit period.

---
 rtl/i2c_read_rdata.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/i2c_read_rdata.sv
// i2c_read_rdata: bit-banged I2C register-read master (START, addr W, reg, RSTART, addr R, data, STOP).
// One PT_CK tick is a quarter of an SCL bit; outputs are registered so the pins never glitch.
module i2c_read_rdata #(
    parameter bit NACK_ABORT = 1'b0
) (
    input  logic        PT_CK,
    input  logic        RESET_N,
    input  logic        GO,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic [7:0]  REG_ADDR,
    input  logic        RD_LEN,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic        END_OK,
    output logic        ACK_ERR,
    output logic [15:0] RDATA,
    output logic [7:0]  ST
);

    typedef enum logic [2:0] {
        IDLE, WAIT_LOW, ARM, START, BIT, RSTART, STOP, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  phase;
    logic [3:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [7:0]  slave_q, reg_q, tx_byte;
    logic        rd_len_q, aborted;
    logic [15:0] rx;
    logic        sdao_d, sclo_d;
    logic        is_ack, is_read, slave_ack_p3, abort;

    // byte_idx: 0 addr(W), 1 register, 2 addr(R), 3/4 read data
    always_comb begin
        case (byte_idx)
            3'd0:    tx_byte = slave_q;
            3'd1:    tx_byte = reg_q;
            default: tx_byte = {slave_q[7:1], 1'b1};
        endcase
    end

    assign is_ack       = (bit_idx == 4'd8);
    assign is_read      = (byte_idx >= 3'd3);
    assign slave_ack_p3 = (state == BIT) && (phase == 2'd3) && is_ack && !is_read;
    assign abort        = NACK_ABORT && slave_ack_p3 && SDAI;
    assign ST           = {5'd0, state};

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sdao_d    = SDAO;
        sclo_d    = SCLO;
        case (state)
            IDLE: begin
                sdao_d = 1'b1;
                sclo_d = 1'b1;
                if (GO) state_nxt = WAIT_LOW;
            end
            WAIT_LOW: if (!GO) state_nxt = ARM;
            ARM:      state_nxt = START;
            START: begin
                sdao_d    = 1'b0;
                sclo_d    = 1'b1;
                state_nxt = BIT;
            end
            BIT: begin
                case (phase)
                    2'd0: sclo_d = 1'b0;
                    2'd1: begin
                        // master ACKs the first of two data bytes, NACKs the last one
                        if (is_ack)
                            sdao_d = is_read ? !(rd_len_q && byte_idx == 3'd3) : 1'b1;
                        else
                            sdao_d = is_read ? 1'b1 : tx_byte[3'd7 - bit_idx[2:0]];
                    end
                    2'd2: sclo_d = 1'b1;
                    default: begin
                        if (abort)
                            state_nxt = STOP;
                        else if (is_ack) begin
                            if (byte_idx == 3'd1)
                                state_nxt = RSTART;
                            else if (byte_idx == 3'd4 || (byte_idx == 3'd3 && !rd_len_q))
                                state_nxt = STOP;
                        end
                    end
                endcase
            end
            RSTART: begin
                sdao_d = (phase != 2'd2);
                sclo_d = (phase != 2'd0);
                if (phase == 2'd2) state_nxt = BIT;
            end
            STOP: begin
                sdao_d = (phase == 2'd2);
                sclo_d = (phase != 2'd0);
                if (phase == 2'd2) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            SDAO     <= 1'b1;
            SCLO     <= 1'b1;
            END_OK   <= 1'b1;
            ACK_ERR  <= 1'b0;
            RDATA    <= 16'h0000;
            phase    <= 2'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 3'd0;
            slave_q  <= 8'h00;
            reg_q    <= 8'h00;
            rd_len_q <= 1'b0;
            aborted  <= 1'b0;
            rx       <= 16'h0000;
        end else begin
            SDAO <= sdao_d;
            SCLO <= sclo_d;
            case (state)
                ARM: begin
                    END_OK   <= 1'b0;
                    ACK_ERR  <= 1'b0;
                    aborted  <= 1'b0;
                    rx       <= 16'h0000;
                    phase    <= 2'd0;
                    bit_idx  <= 4'd0;
                    byte_idx <= 3'd0;
                    slave_q  <= SLAVE_ADDRESS;
                    reg_q    <= REG_ADDR;
                    rd_len_q <= RD_LEN;
                end
                BIT: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (is_ack) begin
                            bit_idx  <= 4'd0;
                            byte_idx <= byte_idx + 3'd1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                        if (slave_ack_p3 && SDAI) ACK_ERR <= 1'b1;
                        if (abort) aborted <= 1'b1;
                        if (is_read && !is_ack) rx <= {rx[14:0], SDAI};
                    end
                end
                RSTART, STOP: phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                DONE: begin
                    END_OK <= 1'b1;
                    if (!aborted) RDATA <= rd_len_q ? rx : {8'h00, rx[7:0]};
                end
                default: ;
            endcase
        end
    end

endmodule
